// File: rtl/restoring_divider_unit.sv
// ---------------------------------------------------------------------------
// restoring_divider_unit
//
// Sequential unsigned restoring divider: 12-bit dividend / 6-bit divisor,
// producing a 6-bit quotient and a 6-bit remainder, one quotient bit per
// three-cycle iteration (SHIFT, SUB, CHECK).
//
// The controller FSM and the datapath (7-bit partial remainder A, 6-bit
// quotient Q, one shared adder/subtractor, 3-bit iteration counter) all live
// in this file. Every flop is <sig>_q, fed by <sig>_d from one always_comb.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous, active-low reset (aborts any operation)
//   start  in   1   operation request, level-sampled; work begins once it
//                   falls again
//   D      in   6   unsigned divisor, sampled in LOAD, held until Done
//   AQ     in  12   unsigned dividend; AQ[11:6] seeds A, AQ[5:0] seeds Q
//   Rem    out  6   remainder (A[5:0]); valid while Done=1
//   Q      out  6   quotient register; valid while Done=1
//   Done   out  1   result-valid level, cleared when the next start is
//                   accepted or on reset
//
// Results are exact when AQ[11:6] < D and D != 0. Otherwise the same six
// iterations still run and whatever the algorithm yields is presented;
// no error flag is produced.
// ---------------------------------------------------------------------------
module restoring_divider_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  D,
  input  logic [11:0] AQ,
  output logic [5:0]  Rem,
  output logic [5:0]  Q,
  output logic        Done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_LOW = 3'd1,
    S_LOAD     = 3'd2,
    S_SHIFT    = 3'd3,
    S_SUB      = 3'd4,
    S_CHECK    = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  // Last iteration index: iterations are numbered 0..5.
  localparam logic [2:0] LAST_ITER = 3'd5;

  state_e      state_q, state_d;
  logic [6:0]  a_q, a_d;       // partial remainder, one guard bit for sign
  logic [5:0]  q_q, q_d;       // quotient / low half of dividend
  logic [2:0]  cnt_q, cnt_d;   // iteration counter
  logic        done_q, done_d;

  // -------------------------------------------------------------------------
  // Shared adder/subtractor. Subtraction is done as A + ~{0,D} + 1 so SUB and
  // the restore step in CHECK use the same 7-bit adder.
  // -------------------------------------------------------------------------
  logic       sub_sel;
  logic [6:0] divisor_ext;
  logic [6:0] addend;
  logic [6:0] sum;

  assign sub_sel     = (state_q == S_SUB);
  assign divisor_ext = {1'b0, D};
  assign addend      = sub_sel ? ~divisor_ext : divisor_ext;
  assign sum         = a_q + addend + {6'd0, sub_sel};

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  // NOTE: every _d gets a default equal to its _q before the case statement,
  // so no branch can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_LOW;
      end

      // Work starts on the falling edge of start so a long pulse still
      // produces exactly one operation.
      S_WAIT_LOW: begin
        if (!start) state_d = S_LOAD;
      end

      S_LOAD: begin
        a_d     = {1'b0, AQ[11:6]};
        q_d     = AQ[5:0];
        cnt_d   = 3'd0;
        done_d  = 1'b0;
        state_d = S_SHIFT;
      end

      // {A,Q} << 1: the top bit of A is dropped (it is always 0 here because
      // the restored partial remainder is < D), Q[5] moves into A[0].
      S_SHIFT: begin
        a_d     = {a_q[5:0], q_q[5]};
        q_d     = {q_q[4:0], 1'b0};
        state_d = S_SUB;
      end

      S_SUB: begin
        a_d     = sum;
        state_d = S_CHECK;
      end

      // Negative trial remainder: restore it and leave the quotient bit 0.
      S_CHECK: begin
        if (a_q[6]) begin
          a_d    = sum;
          q_d[0] = 1'b0;
        end else begin
          q_d[0] = 1'b1;
        end
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == LAST_ITER) ? S_DONE : S_SHIFT;
      end

      // Done becomes visible on the first DONE edge and holds until the next
      // start is accepted.
      S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          state_d = S_WAIT_LOW;
        end else begin
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers with synchronous active-low reset
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= 7'd0;
      q_q     <= 6'd0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign Rem  = a_q[5:0];
  assign Q    = q_q;
  assign Done = done_q;

endmodule

// File: tb/tb_restoring_divider_unit.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for restoring_divider_unit.
// Inputs are driven on the falling clock edge; outputs are sampled there too.
// Edge 0 is the first rising edge that sees start=0 in WAIT_LOW; Done must be
// low after edge 19 and high after edge 20.
// ---------------------------------------------------------------------------
module tb_restoring_divider_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  d_i;
  logic [11:0] aq_i;
  logic [5:0]  rem_o;
  logic [5:0]  q_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  restoring_divider_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .D     (d_i),
    .AQ    (aq_i),
    .Rem   (rem_o),
    .Q     (q_o),
    .Done  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Request an operation: raise start for 'hold' cycles, then drop it.
  // Returns right after a falling edge with start=0, so the next rising edge
  // is edge 0. Done must already be low one edge after start is seen.
  task automatic start_op(input logic [5:0] d, input logic [11:0] aq, input int hold);
    @(negedge clk);
    d_i   = d;
    aq_i  = aq;
    start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) check("done_drop", int'(done_o), 0);
    end
    start = 1'b0;
  endtask

  // Count edges from edge 0 until Done is seen; bounded.
  task automatic wait_done(output int edge_no);
    edge_no = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (done_o) begin
        edge_no = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] d, input logic [11:0] aq,
                        input int hold, input int exp_q, input int exp_rem);
    int edge_no;
    start_op(d, aq, hold);
    wait_done(edge_no);
    check({tag, "_latency"}, edge_no, 20);
    check({tag, "_q"}, int'(q_o), exp_q);
    check({tag, "_rem"}, int'(rem_o), exp_rem);
  endtask

  initial begin
    int edge_no;
    rst   = 1'b0;
    start = 1'b0;
    d_i   = 6'd0;
    aq_i  = 12'd0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check("rst_q", int'(q_o), 0);
    check("rst_rem", int'(rem_o), 0);
    check("rst_done", int'(done_o), 0);
    rst = 1'b1;

    // Basic divide with a 2-cycle start pulse: 88 / 8 = 11 r 0.
    run_op("div_88_8", 6'd8, 12'd88, 2, 11, 0);

    // Back-to-back operations.
    run_op("div_75_11", 6'd11, 12'd75, 1, 6, 9);
    run_op("div_2000_51", 6'd51, 12'd2000, 1, 39, 11);

    // Near-max quotients.
    run_op("div_1876_56", 6'd56, 12'd1876, 1, 33, 28);
    run_op("div_4031_63", 6'd63, 12'd4031, 1, 63, 62);

    // Edge operands.
    run_op("div_0_5", 6'd5, 12'd0, 1, 0, 0);
    run_op("div_63_1", 6'd1, 12'd63, 1, 63, 0);

    // start held for 5 cycles: no LOAD while high, previous quotient (63)
    // and remainder (0) stay put. 1000 / 23 = 43 r 11.
    @(negedge clk);
    d_i   = 6'd23;
    aq_i  = 12'd1000;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done_low", int'(done_o), 0);
      check("hold_q_kept", int'(q_o), 63);
    end
    start = 1'b0;
    wait_done(edge_no);
    check("hold_latency", edge_no, 20);
    check("hold_q", int'(q_o), 43);
    check("hold_rem", int'(rem_o), 11);

    // Exactly one operation: result and Done stay put afterwards.
    repeat (30) @(negedge clk);
    check("one_op_done", int'(done_o), 1);
    check("one_op_q", int'(q_o), 43);
    check("one_op_rem", int'(rem_o), 11);

    // start pulsed mid-operation is ignored: 500 / 9 = 55 r 5.
    start_op(6'd9, 12'd500, 1);
    repeat (8) @(negedge clk);          // edges 0..7
    start = 1'b1;
    repeat (2) @(negedge clk);          // edges 8..9
    start = 1'b0;
    edge_no = -1;
    for (int k = 10; k < 64; k++) begin
      @(negedge clk);
      if (done_o) begin
        edge_no = k;
        break;
      end
    end
    check("busy_start_latency", edge_no, 20);
    check("busy_start_q", int'(q_o), 55);
    check("busy_start_rem", int'(rem_o), 5);

    // Reset during iteration 3 (its SHIFT is edge 8); 900 / 17 aborted.
    start_op(6'd17, 12'd900, 1);
    repeat (9) @(negedge clk);          // edges 0..8
    rst = 1'b0;
    @(negedge clk);                     // edge 9 under reset
    check("midrst_q", int'(q_o), 0);
    check("midrst_rem", int'(rem_o), 0);
    check("midrst_done", int'(done_o), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_idle_done", int'(done_o), 0);

    // Fresh operation after the abort: 700 / 13 = 53 r 11.
    run_op("div_700_13", 6'd13, 12'd700, 1, 53, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoring_divider_unit.md
Name: restoring_divider_unit

Overview:
- Sequential unsigned restoring divider: divides a 12-bit dividend by a 6-bit divisor and produces a 6-bit quotient and a 6-bit remainder.
- Built internally from a controller FSM and a datapath: a 7-bit partial-remainder register A, a 6-bit quotient register Q, a shared adder/subtractor and an iteration counter.
- Used as a standalone arithmetic block with a start/Done handshake.

Parameters:
- None. Widths are fixed: dividend 12, divisor 6, quotient 6, remainder 6.

Ports:
- clk    input   1   rising-edge clock
- rst    input   1   synchronous, active-low reset
- start  input   1   operation request, level-sampled
- D      input   6   unsigned divisor
- AQ     input   12  unsigned dividend; AQ[11:6] goes to A, AQ[5:0] goes to Q
- Rem    output  6   remainder, equal to A[5:0]
- Q      output  6   quotient register
- Done   output  1   result valid

Behaviour:
- Reset: on a clk edge with rst=0, state becomes IDLE and A, Q, the counter and Done are all cleared, so Q=0, Rem=0, Done=0. Reset wins over all other activity, including reset in the middle of an operation, which aborts it.
- FSM states and transitions:
  - IDLE: if start=1, go to WAIT_LOW.
  - WAIT_LOW: if start=0, go to LOAD; otherwise stay.
  - LOAD: A <= {1'b0, AQ[11:6]}, Q <= AQ[5:0], counter <= 0, Done <= 0; go to SHIFT.
  - SHIFT: {A,Q} <= {A,Q} << 1 with the vacated Q[0]=0; go to SUB.
  - SUB: A <= A - {1'b0,D}, 7-bit two's complement; go to CHECK.
  - CHECK: if A[6]=1 (negative), A <= A + {1'b0,D} and Q[0] <= 0; else Q[0] <= 1. Counter increments. If counter reached 5 (6th iteration), go to DONE; else go to SHIFT.
  - DONE: Done=1 and Q/Rem hold. If start=1, go to WAIT_LOW and drop Done.
- Handshake:
  - One operation per start pulse. D and AQ are sampled in LOAD, the cycle after start is seen low.
  - D must stay stable from LOAD until Done.
  - start asserted while busy (SHIFT/SUB/CHECK) is ignored.
- Latency: counting the edge where WAIT_LOW samples start=0 as edge 0, Done goes high after edge 20. That is 1 cycle to reach LOAD, 1 LOAD cycle and 6 iterations of 3 cycles each.
- Done is a level, not a pulse. It stays 1 until the next start is accepted or reset occurs.
- Arithmetic:
  - Unsigned throughout. A is 7 bits so the shifted partial remainder (< 2D) never overflows.
  - Precondition: AQ[11:6] < D and D != 0. When the precondition is violated, the block still runs the same 6 iterations and outputs whatever the algorithm yields; no error flag is raised.
  - When the precondition holds: Q = floor(AQ/D) and Rem = AQ mod D, with Rem < D.
- During an operation Q and Rem show intermediate values; they are valid only while Done=1.

Test Plan:
- Reset then basic divide: hold rst=0 for 2 cycles, release, D=8, AQ=88, start pulse of 2 cycles -> Done=1 after 20 edges from start fall, Q=11, Rem=0.
- Back-to-back operations: after Done, D=11 and AQ=75 with a start pulse -> Done drops, then returns with Q=6, Rem=9. Next D=51, AQ=2000 -> Q=39, Rem=11.
- Near-max quotient: D=56, AQ=1876 -> Q=33, Rem=28. Also D=63, AQ=4031 -> Q=63, Rem=62.
- Edge operands: AQ=0, D=5 -> Q=0, Rem=0. D=1, AQ=63 -> Q=63, Rem=0.
- Handshake: hold start high for 5 cycles -> no LOAD until start falls, and exactly one operation runs. A start asserted mid-operation is ignored and the result is unchanged.
- Reset mid-operation: drive rst=0 at iteration 3 -> next edge gives Q=0, Rem=0, Done=0 and state IDLE. A new start then gives a correct result.
